// File: rtl/fwd_hazard_if.sv
// Bundle between the ID/EX pipeline control and the forwarding/hazard unit.
// master: pipeline side (drives ID record and branch outcome, consumes controls).
// slave : fwd_hazard_unit side.
// Signals:
//   id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_reg_write, id_mem_read,
//   id_dst, ex_branch_taken            pipeline -> unit
//   fwd_a_ctrl1/2, fwd_b_ctrl1/2       unit -> EX operand muxes (registered)
//   pc_stall, ifid_stall, ifid_flush,
//   idex_bubble                        unit -> pipeline registers (combinational)
interface fwd_hazard_if #(
    parameter int unsigned REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_reg_write;
    logic              id_mem_read;
    logic [REG_AW-1:0] id_dst;
    logic              ex_branch_taken;

    logic              fwd_a_ctrl1;
    logic              fwd_a_ctrl2;
    logic              fwd_b_ctrl1;
    logic              fwd_b_ctrl2;
    logic              pc_stall;
    logic              ifid_stall;
    logic              ifid_flush;
    logic              idex_bubble;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_reg_write, id_mem_read, id_dst, ex_branch_taken,
        input  fwd_a_ctrl1, fwd_a_ctrl2, fwd_b_ctrl1, fwd_b_ctrl2,
               pc_stall, ifid_stall, ifid_flush, idex_bubble
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_reg_write, id_mem_read, id_dst, ex_branch_taken,
        output fwd_a_ctrl1, fwd_a_ctrl2, fwd_b_ctrl1, fwd_b_ctrl2,
               pc_stall, ifid_stall, ifid_flush, idex_bubble
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and hazard control for a 5-stage pipeline.
// Keeps a shift scoreboard of the producers in EX and MEM and, from the
// instruction in ID, computes:
//   - registered one-hot forward selects for ALU operands A/B
//     (ctrl1 = EX/MEM result, ctrl2 = MEM/WB data), valid while the
//     instruction sits in EX;
//   - combinational load-use stall (pc_stall, ifid_stall, idex_bubble),
//     held for LU_STALL cycles (1 or 2);
//   - combinational taken-branch flush (ifid_flush, idex_bubble).
// Ports: clk, rst_n (async active-low), hz (fwd_hazard_if slave modport).
// The WB slot is not held: a WB producer never forwards (the regfile writes
// in the first half-cycle) and never stalls, so it cannot affect any output.
module fwd_hazard_unit #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LU_STALL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    fwd_hazard_if.slave hz
);
    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        logic              v;
        logic              wr;
        logic              ld;
        logic [REG_AW-1:0] dst;
    } sb_entry_t;

    sb_entry_t        ex_q, ex_d;
    sb_entry_t        mem_q, mem_d;
    sb_entry_t        id_rec_c;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic fwd_a1_q, fwd_a1_d;
    logic fwd_a2_q, fwd_a2_d;
    logic fwd_b1_q, fwd_b1_d;
    logic fwd_b2_q, fwd_b2_d;

    logic ex_rs_c, ex_rt_c, mem_rs_c, mem_rt_c;
    logic lu_ex_c, lu_mem_c;
    logic branch_c, stall_c, bubble_c;

    // Scoreboard entry s produces register r that the ID instruction reads.
    function automatic logic match(input sb_entry_t         s,
                                   input logic [REG_AW-1:0] r,
                                   input logic              use_r,
                                   input logic              valid);
        return s.v & s.wr & (s.dst == r) & (r != '0) & use_r & valid;
    endfunction

    // Hazard detection, next scoreboard and next forward selects.
    always_comb begin
        id_rec_c = '0;
        ex_d     = '0;
        mem_d    = '0;
        cnt_d    = '0;
        fwd_a1_d = 1'b0;
        fwd_a2_d = 1'b0;
        fwd_b1_d = 1'b0;
        fwd_b2_d = 1'b0;

        id_rec_c.v   = hz.id_valid;
        id_rec_c.wr  = hz.id_reg_write;
        id_rec_c.ld  = hz.id_mem_read;
        id_rec_c.dst = hz.id_dst;

        ex_rs_c  = match(ex_q,  hz.id_rs, hz.id_use_rs, hz.id_valid);
        ex_rt_c  = match(ex_q,  hz.id_rt, hz.id_use_rt, hz.id_valid);
        mem_rs_c = match(mem_q, hz.id_rs, hz.id_use_rs, hz.id_valid);
        mem_rt_c = match(mem_q, hz.id_rt, hz.id_use_rt, hz.id_valid);

        lu_ex_c  = ex_q.ld & (ex_rs_c | ex_rt_c);
        // Second stall cycle: the load has moved to MEM and still cannot forward.
        lu_mem_c = (LU_STALL == 32'd2) & (cnt_q == CNT_W'(1))
                 & mem_q.ld & (mem_rs_c | mem_rt_c);

        // A taken branch discards the ID instruction, so it beats load-use.
        branch_c = hz.ex_branch_taken;
        stall_c  = ~branch_c & (lu_ex_c | lu_mem_c) & (cnt_q < CNT_W'(LU_STALL));
        bubble_c = stall_c | branch_c;

        cnt_d = stall_c ? cnt_q + CNT_W'(1) : '0;
        ex_d  = bubble_c ? '0 : id_rec_c;
        mem_d = ex_q;

        // Youngest producer wins; a bubble entering EX carries no selects.
        fwd_a1_d = ~bubble_c & ex_rs_c & ~ex_q.ld;
        fwd_a2_d = ~bubble_c & ~fwd_a1_d & mem_rs_c;
        fwd_b1_d = ~bubble_c & ex_rt_c & ~ex_q.ld;
        fwd_b2_d = ~bubble_c & ~fwd_b1_d & mem_rt_c;
    end

    // Scoreboard, stall counter and forward-select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= '0;
            mem_q    <= '0;
            cnt_q    <= '0;
            fwd_a1_q <= 1'b0;
            fwd_a2_q <= 1'b0;
            fwd_b1_q <= 1'b0;
            fwd_b2_q <= 1'b0;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            cnt_q    <= cnt_d;
            fwd_a1_q <= fwd_a1_d;
            fwd_a2_q <= fwd_a2_d;
            fwd_b1_q <= fwd_b1_d;
            fwd_b2_q <= fwd_b2_d;
        end
    end

    assign hz.fwd_a_ctrl1 = fwd_a1_q;
    assign hz.fwd_a_ctrl2 = fwd_a2_q;
    assign hz.fwd_b_ctrl1 = fwd_b1_q;
    assign hz.fwd_b_ctrl2 = fwd_b2_q;

    // Pipeline controls are forced low while reset is asserted.
    assign hz.pc_stall    = rst_n & stall_c;
    assign hz.ifid_stall  = rst_n & stall_c;
    assign hz.ifid_flush  = rst_n & branch_c;
    assign hz.idex_bubble = rst_n & bubble_c;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: one instance with LU_STALL=1 (index 0) and one
// with LU_STALL=2 (index 1), driven with the same ID stream. Directed
// scenarios plus a randomized run against a per-instance reference model.
module tb_fwd_hazard_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_use_rs = 1'b0;
    logic       id_use_rt = 1'b0;
    logic       id_reg_write = 1'b0;
    logic       id_mem_read = 1'b0;
    logic [4:0] id_dst = '0;
    logic       ex_branch_taken = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fwd_hazard_if #(.REG_AW(5)) if1 ();
    fwd_hazard_if #(.REG_AW(5)) if2 ();

    assign if1.id_valid = id_valid;        assign if2.id_valid = id_valid;
    assign if1.id_rs = id_rs;              assign if2.id_rs = id_rs;
    assign if1.id_rt = id_rt;              assign if2.id_rt = id_rt;
    assign if1.id_use_rs = id_use_rs;      assign if2.id_use_rs = id_use_rs;
    assign if1.id_use_rt = id_use_rt;      assign if2.id_use_rt = id_use_rt;
    assign if1.id_reg_write = id_reg_write; assign if2.id_reg_write = id_reg_write;
    assign if1.id_mem_read = id_mem_read;  assign if2.id_mem_read = id_mem_read;
    assign if1.id_dst = id_dst;            assign if2.id_dst = id_dst;
    assign if1.ex_branch_taken = ex_branch_taken;
    assign if2.ex_branch_taken = ex_branch_taken;

    fwd_hazard_unit #(.REG_AW(5), .LU_STALL(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .hz(if1));
    fwd_hazard_unit #(.REG_AW(5), .LU_STALL(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .hz(if2));

    // {a_ctrl1, a_ctrl2, b_ctrl1, b_ctrl2} and {pc_stall, ifid_stall, ifid_flush, idex_bubble}
    logic [3:0] obs_fwd  [2];
    logic [3:0] obs_comb [2];
    assign obs_fwd[0]  = {if1.fwd_a_ctrl1, if1.fwd_a_ctrl2, if1.fwd_b_ctrl1, if1.fwd_b_ctrl2};
    assign obs_fwd[1]  = {if2.fwd_a_ctrl1, if2.fwd_a_ctrl2, if2.fwd_b_ctrl1, if2.fwd_b_ctrl2};
    assign obs_comb[0] = {if1.pc_stall, if1.ifid_stall, if1.ifid_flush, if1.idex_bubble};
    assign obs_comb[1] = {if2.pc_stall, if2.ifid_stall, if2.ifid_flush, if2.idex_bubble};

    // Reference model: history of what entered EX (age 0 = in EX, age 1 = in MEM).
    typedef struct packed {
        logic       v;
        logic       wr;
        logic       ld;
        logic [4:0] dst;
    } rec_t;

    rec_t       hist [2][2];
    int         stall_cycles [2];
    logic [3:0] exp_comb [2];
    logic [3:0] exp_fwd  [2];
    logic [3:0] nxt_fwd  [2];
    logic       m_stall  [2];
    logic       m_bub    [2];

    // 0 none, 1 EX ALU producer, 2 MEM ALU producer, 3 EX load, 4 MEM load (youngest wins)
    function automatic int producer(int k, logic [4:0] r, logic use_r);
        if (!(id_valid && use_r && r != 5'd0)) return 0;
        if (hist[k][0].v && hist[k][0].wr && hist[k][0].dst == r) return hist[k][0].ld ? 3 : 1;
        if (hist[k][1].v && hist[k][1].wr && hist[k][1].dst == r) return hist[k][1].ld ? 4 : 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            hist[k][0] = '0;
            hist[k][1] = '0;
            stall_cycles[k] = 0;
            exp_fwd[k] = '0;
        end
    endtask

    task automatic model_eval();
        for (int k = 0; k < 2; k++) begin
            int  lu = k + 1;
            int  pa = producer(k, id_rs, id_use_rs);
            int  pb = producer(k, id_rt, id_use_rt);
            bit  need = (pa == 3 || pb == 3) ||
                        (lu == 2 && stall_cycles[k] == 1 && (pa == 4 || pb == 4));
            m_stall[k]  = !ex_branch_taken && need && stall_cycles[k] < lu;
            m_bub[k]    = ex_branch_taken || m_stall[k];
            exp_comb[k] = {m_stall[k], m_stall[k], ex_branch_taken, m_bub[k]};
            nxt_fwd[k]  = m_bub[k] ? 4'b0000 :
                          {pa == 1, (pa == 2 || pa == 4), pb == 1, (pb == 2 || pb == 4)};
        end
    endtask

    task automatic model_advance();
        for (int k = 0; k < 2; k++) begin
            hist[k][1] = hist[k][0];
            hist[k][0] = m_bub[k] ? rec_t'(0) : {id_valid, id_reg_write, id_mem_read, id_dst};
            stall_cycles[k] = m_stall[k] ? stall_cycles[k] + 1 : 0;
            exp_fwd[k] = nxt_fwd[k];
        end
    endtask

    // Present an ID record after the falling edge; combinational outputs settle by return.
    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic wr,
                         input logic ld, input logic [4:0] dst, input logic br);
        @(negedge clk);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_reg_write = wr; id_mem_read = ld; id_dst = dst; ex_branch_taken = br;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_advance();
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        id_valid = 1'b0; ex_branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        id_valid = 1'b1; id_rs = 5'd3; id_use_rs = 1'b1; ex_branch_taken = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks += 2;
            if (obs_comb[k] !== 4'b0000) begin
                n_fail++; $display("FAIL reset_comb dut%0d: got %b want 0000", k, obs_comb[k]);
            end
            if (obs_fwd[k] !== 4'b0000) begin
                n_fail++; $display("FAIL reset_fwd dut%0d: got %b want 0000", k, obs_fwd[k]);
            end
        end
        do_reset();
    endtask

    task automatic test_fwd_ex();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0); tick();   // add r3
        drive(1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0);           // sub r5, r3, r9
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_comb[k] !== 4'b0000) begin
                n_fail++; $display("FAIL fwd_ex_nostall dut%0d: got %b want 0000", k, obs_comb[k]);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_fwd[k] !== 4'b1000) begin
                n_fail++; $display("FAIL fwd_ex dut%0d: got %b want 1000", k, obs_fwd[k]);
            end
        end
        nop();
        n_checks++;
        if (obs_fwd[0] !== 4'b0000) begin
            n_fail++; $display("FAIL fwd_ex_clear: got %b want 0000", obs_fwd[0]);
        end
    endtask

    task automatic test_fwd_mem();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0); tick();   // add r3
        nop();
        drive(1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0); tick();   // sub rt=r3
        n_checks++;
        if (obs_fwd[0] !== 4'b0001) begin
            n_fail++; $display("FAIL fwd_mem: got %b want 0001", obs_fwd[0]);
        end
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0); tick();   // add r3
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0); tick();   // add r3 again
        drive(1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0); tick();   // sub rt=r3
        n_checks++;
        if (obs_fwd[1] !== 4'b0010) begin
            n_fail++; $display("FAIL fwd_youngest: got %b want 0010", obs_fwd[1]);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0); tick();   // lw r4
        drive(1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0);           // uses r4
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_comb[k] !== 4'b1101) begin
                n_fail++; $display("FAIL lu_stall1 dut%0d: got %b want 1101", k, obs_comb[k]);
            end
        end
        tick();
        drive(1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0);           // held in ID
        n_checks += 2;
        if (obs_comb[0] !== 4'b0000) begin
            n_fail++; $display("FAIL lu_release_lu1: got %b want 0000", obs_comb[0]);
        end
        if (obs_comb[1] !== 4'b1101) begin
            n_fail++; $display("FAIL lu_stall2_lu2: got %b want 1101", obs_comb[1]);
        end
        tick();
        n_checks += 2;
        if (obs_fwd[0] !== 4'b0100) begin
            n_fail++; $display("FAIL lu_fwd_lu1: got %b want 0100", obs_fwd[0]);
        end
        if (obs_fwd[1] !== 4'b0000) begin
            n_fail++; $display("FAIL lu_bubble_lu2: got %b want 0000", obs_fwd[1]);
        end
        drive(1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0);
        n_checks++;
        if (obs_comb[1] !== 4'b0000) begin
            n_fail++; $display("FAIL lu_release_lu2: got %b want 0000", obs_comb[1]);
        end
        tick();
        n_checks++;
        if (obs_fwd[1] !== 4'b0000) begin
            n_fail++; $display("FAIL lu_wb_nofwd_lu2: got %b want 0000", obs_fwd[1]);
        end
    endtask

    task automatic test_r0_and_use();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0); tick();   // write r0
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0); tick();   // read r0
        n_checks++;
        if (obs_fwd[0] !== 4'b0000) begin
            n_fail++; $display("FAIL r0_nofwd: got %b want 0000", obs_fwd[0]);
        end
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0); tick();   // lw r0
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0);
        n_checks++;
        if (obs_comb[0] !== 4'b0000) begin
            n_fail++; $display("FAIL r0_nostall: got %b want 0000", obs_comb[0]);
        end
        tick();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0); tick();   // add r7
        drive(1'b1, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0); tick();   // r7 not used
        n_checks++;
        if (obs_fwd[0] !== 4'b0000) begin
            n_fail++; $display("FAIL unused_nofwd: got %b want 0000", obs_fwd[0]);
        end
    endtask

    task automatic test_branch_beats_lu();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0); tick();   // lw r4
        drive(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1);           // use + branch
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_comb[k] !== 4'b0011) begin
                n_fail++; $display("FAIL branch_comb dut%0d: got %b want 0011", k, obs_comb[k]);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_fwd[k] !== 4'b0000) begin
                n_fail++; $display("FAIL branch_fwd dut%0d: got %b want 0000", k, obs_fwd[k]);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0); tick();   // lw r4
        drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0);
        n_checks++;
        if (obs_comb[1] !== 4'b1101) begin
            n_fail++; $display("FAIL midrst_prestall: got %b want 1101", obs_comb[1]);
        end
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks += 2;
            if (obs_comb[k] !== 4'b0000) begin
                n_fail++; $display("FAIL midrst_comb dut%0d: got %b want 0000", k, obs_comb[k]);
            end
            if (obs_fwd[k] !== 4'b0000) begin
                n_fail++; $display("FAIL midrst_fwd dut%0d: got %b want 0000", k, obs_fwd[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0); tick();   // add r6
        drive(1'b1, 5'd6, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0); tick();   // reads r6
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_fwd[k] !== 4'b1000) begin
                n_fail++; $display("FAIL midrst_after dut%0d: got %b want 1000", k, obs_fwd[k]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 7) != 0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_comb[k] !== exp_comb[k]) begin
                    n_fail++;
                    $display("FAIL rand_comb dut%0d cyc%0d: got %b want %b", k, i, obs_comb[k], exp_comb[k]);
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_fwd[k] !== exp_fwd[k]) begin
                    n_fail++;
                    $display("FAIL rand_fwd dut%0d cyc%0d: got %b want %b", k, i, obs_fwd[k], exp_fwd[k]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fwd_ex();
        test_fwd_mem();
        test_load_use();
        test_r0_and_use();
        test_branch_beats_lu();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
